decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/riscv_pkg.sv | 46 ++++
 rtl/imm_gen.sv | 23 ++
 rtl/decode_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, instruction field positions, immediate formats
// and the decode output register layout.
package riscv_pkg;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   localparam int OPC_LSB = 0;
   localparam int RD_LSB  = 7;
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;

   typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
   } id_reg_t;

   // Unknown opcodes fall into IMM_R, which yields a zero immediate.
   function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
      case (opc)
         OP_IMM, LOAD, JALR: return IMM_I;
         STORE:              return IMM_S;
         BRANCH:             return IMM_B;
         LUI, AUIPC:         return IMM_U;
         JAL:                return IMM_J;
         default:            return IMM_R;
      endcase
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator (I/S/B/U/J, sign-extended; zero otherwise).
module imm_gen
   import riscv_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic [31:0] imm_o
);

   always_comb begin
      imm_o = '0;
      case (imm_fmt(instr_i[OPC_LSB +: 7]))
         IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
         IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
         IMM_U: imm_o = {instr_i[31:12], 12'b0};
         IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
         default: imm_o = '0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: operand read with bypass, hazard stall, one output register.
// Define DECODE_FORWARDING_EN to enable EX/MEM bypass; otherwise EX/MEM hazards stall.
module decode_stage
   import riscv_pkg::*;
(
   input  logic        clock_i,
   input  logic        reset_n_i,
   input  logic        instr_valid_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   output logic        instr_ready_o,
   output logic [4:0]  rf_rd_register_1_o,
   output logic [4:0]  rf_rd_register_2_o,
   input  logic [31:0] rf_rd_data_1_i,
   input  logic [31:0] rf_rd_data_2_i,
   input  logic [4:0]  ex_rd_i,
   input  logic        ex_reg_write_i,
   input  logic        ex_mem_read_i,
   input  logic [31:0] ex_result_i,
   input  logic [4:0]  mem_rd_i,
   input  logic        mem_reg_write_i,
   input  logic [31:0] mem_result_i,
   input  logic [4:0]  wb_rd_i,
   input  logic        wb_reg_write_i,
   input  logic [31:0] wb_data_i,
   input  logic        flush_i,
   input  logic        ex_ready_i,
   output logic        id_valid_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_instr_o,
   output logic [31:0] id_rs1_data_o,
   output logic [31:0] id_rs2_data_o,
   output logic [31:0] id_imm_o,
   output logic [4:0]  id_rd_o,
   output logic        id_reg_write_o,
   output logic        id_mem_read_o
);

   id_reg_t     id_q, id_d;
   logic [6:0]  opc;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm;
   logic        rs1_used, rs2_used, legal, load_use, stall, advance, xfer;

   assign opc = instr_i[OPC_LSB +: 7];
   assign rs1 = instr_i[RS1_LSB +: 5];
   assign rs2 = instr_i[RS2_LSB +: 5];
   assign rd  = instr_i[RD_LSB  +: 5];

   assign rf_rd_register_1_o = rs1;
   assign rf_rd_register_2_o = rs2;

   imm_gen u_imm_gen (.instr_i(instr_i), .imm_o(imm));

   assign rs1_used = !(opc == LUI || opc == AUIPC || opc == JAL);
   assign rs2_used = (opc == OP || opc == STORE || opc == BRANCH);
   assign legal    = (opc == OP || opc == OP_IMM || opc == LOAD || opc == STORE ||
                      opc == BRANCH || opc == JAL || opc == JALR || opc == LUI ||
                      opc == AUIPC);

   function automatic logic hits(input logic [4:0] wrd);
      return (wrd != 5'd0) && ((rs1_used && wrd == rs1) || (rs2_used && wrd == rs2));
   endfunction

   // WB is always bypassed: the register file is written on the same edge we capture.
   function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
      if (rs == 5'd0) return '0;
`ifdef DECODE_FORWARDING_EN
      if (ex_reg_write_i && !ex_mem_read_i && ex_rd_i == rs) return ex_result_i;
      if (mem_reg_write_i && mem_rd_i == rs) return mem_result_i;
`endif
      if (wb_reg_write_i && wb_rd_i == rs) return wb_data_i;
      return rf;
   endfunction

   assign load_use = ex_reg_write_i && ex_mem_read_i && hits(ex_rd_i);

`ifdef DECODE_FORWARDING_EN
   assign stall = load_use;
`else
   logic unused_results;
   assign unused_results = ^{ex_result_i, mem_result_i};
   assign stall = load_use || (ex_reg_write_i && hits(ex_rd_i)) ||
                  (mem_reg_write_i && hits(mem_rd_i));
`endif

   assign advance       = !id_q.valid || ex_ready_i;
   assign instr_ready_o = reset_n_i && advance && !stall && !flush_i;
   assign xfer          = instr_valid_i && instr_ready_o;

   always_comb begin
      id_d = id_q;
      if (flush_i) begin
         id_d.valid = 1'b0;
      end else if (advance) begin
         if (xfer) begin
            id_d.valid     = 1'b1;
            id_d.pc        = pc_i;
            id_d.instr     = instr_i;
            id_d.rs1_data  = operand(rs1, rf_rd_data_1_i);
            id_d.rs2_data  = operand(rs2, rf_rd_data_2_i);
            id_d.imm       = imm;
            id_d.rd        = rd;
            id_d.reg_write = legal && opc != STORE && opc != BRANCH;
            id_d.mem_read  = (opc == LOAD);
         end else begin
            id_d.valid = 1'b0;
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) id_q <= '0;
      else            id_q <= id_d;
   end

   assign id_valid_o     = id_q.valid;
   assign id_pc_o        = id_q.pc;
   assign id_instr_o     = id_q.instr;
   assign id_rs1_data_o  = id_q.rs1_data;
   assign id_rs2_data_o  = id_q.rs2_data;
   assign id_imm_o       = id_q.imm;
   assign id_rd_o        = id_q.rd;
   assign id_reg_write_o = id_q.reg_write;
   assign id_mem_read_o  = id_q.mem_read;

endmodule
